// File: rtl/nibble_sender_pkg.sv
// Shared definitions for the nibble serialiser: FSM encoding, nibble width
// and the counter-width rule.
package nibble_sender_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int cnt_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/nibble_sender.sv
// Serialises a NIBBLES*4-bit word into a 4-bit sink register, most-significant
// nibble first, with sink back-pressure and a one-cycle completion pulse.
module nibble_sender
  import nibble_sender_pkg::*;
#(
  parameter int NIBBLES = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NIBBLE_W*NIBBLES-1:0] In,
  input  logic                        start,
  input  logic                        sink_ready,
  output logic [NIBBLE_W-1:0]         Out,
  output logic                        enable,
  output logic                        busy,
  output logic                        done
);

  localparam int SHIFT_W = NIBBLE_W * NIBBLES;
  localparam int CNT_W   = cnt_width(NIBBLES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

  state_e               state_q, state_d;
  logic [SHIFT_W-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]     cnt_q,   cnt_d;

  // State, shift register and counter; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shift_q <= {SHIFT_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: a nibble leaves only in SEND cycles where the sink is ready.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shift_d = In;
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_SEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (sink_ready) begin
          shift_d = {shift_q[SHIFT_W-NIBBLE_W-1:0], {NIBBLE_W{1'b0}}};
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SEND;
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from the current state; enable follows sink_ready only in SEND.
  always_comb begin
    Out    = 4'b0000;
    enable = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
      end
      ST_SEND: begin
        Out    = shift_q[SHIFT_W-1 -: NIBBLE_W];
        enable = sink_ready;
        busy   = 1'b1;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_nibble_sender.sv
// Bench for nibble_sender: two instances (2 and 4 nibbles) checked every cycle
// against a remaining-nibbles model, plus literal checks of emitted sequences.
module tb_nibble_sender;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in0 = 8'h00;
  logic [15:0] in1 = 16'h0000;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic        rdy0 = 1'b1, rdy1 = 1'b1;
  logic [3:0]  out0, out1;
  logic        en0, en1, busy0, busy1, done0, done1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  nibble_sender #(.NIBBLES(2)) u_dut2 (
    .clk(clk), .reset(reset), .In(in0), .start(start0), .sink_ready(rdy0),
    .Out(out0), .enable(en0), .busy(busy0), .done(done0)
  );

  nibble_sender #(.NIBBLES(4)) u_dut4 (
    .clk(clk), .reset(reset), .In(in1), .start(start1), .sink_ready(rdy1),
    .Out(out1), .enable(en1), .busy(busy1), .done(done1)
  );

  // Model: a word being sent plus how many of its nibbles are still owed,
  // and a flag for the completion cycle that follows the last transfer.
  logic [31:0] m_word[2];
  int          m_rem[2];
  bit          m_done[2];
  bit          m_valid = 1'b0;
  int          m_n[2];
  assign m_n[0] = 2;
  assign m_n[1] = 4;

  logic [31:0] in_a[2];
  logic        st_a[2], rdy_a[2];
  logic [3:0]  out_a[2];
  logic        en_a[2], busy_a[2], done_a[2];
  always_comb begin
    in_a[0] = 32'(in0);   in_a[1] = 32'(in1);
    st_a[0] = start0;     st_a[1] = start1;
    rdy_a[0] = rdy0;      rdy_a[1] = rdy1;
    out_a[0] = out0;      out_a[1] = out1;
    en_a[0] = en0;        en_a[1] = en1;
    busy_a[0] = busy0;    busy_a[1] = busy1;
    done_a[0] = done0;    done_a[1] = done1;
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_rem[k]  = 0;
        m_done[k] = 1'b0;
      end else if (m_done[k]) begin
        m_done[k] = 1'b0;
      end else if (m_rem[k] > 0) begin
        if (rdy_a[k]) begin
          m_rem[k] = m_rem[k] - 1;
          if (m_rem[k] == 0) m_done[k] = 1'b1;
        end
      end else if (st_a[k]) begin
        m_word[k] = in_a[k];
        m_rem[k]  = m_n[k];
      end
    end
    if (reset) m_valid = 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transfer log: nibbles seen on enable cycles and count of done pulses.
  logic [3:0] log_a[2][64];
  int         log_n[2] = '{0, 0};
  int         done_n[2] = '{0, 0};

  always @(negedge clk) begin
    if (m_valid) begin
      for (int k = 0; k < 2; k++) begin
        logic [3:0] e_out;
        e_out = (m_rem[k] > 0) ? 4'((m_word[k] >> (4 * (m_rem[k] - 1))) & 32'hF) : 4'h0;
        chk($sformatf("out[%0d]", k),    32'(out_a[k]),  32'(e_out));
        chk($sformatf("enable[%0d]", k), 32'(en_a[k]),   32'((m_rem[k] > 0) && rdy_a[k]));
        chk($sformatf("busy[%0d]", k),   32'(busy_a[k]), 32'((m_rem[k] > 0) || m_done[k]));
        chk($sformatf("done[%0d]", k),   32'(done_a[k]), 32'(m_done[k]));
        if (en_a[k] === 1'b1 && log_n[k] < 64) begin
          log_a[k][log_n[k]] = out_a[k];
          log_n[k] = log_n[k] + 1;
        end
        if (done_a[k] === 1'b1) done_n[k] = done_n[k] + 1;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Compare the log since (base, dbase) with cnt nibbles of exp, MSB first.
  task automatic check_log(input string name, input int k, input int base, input int dbase,
                           input logic [31:0] exp, input int cnt, input int ndone);
    chk({name, "_count"}, 32'(log_n[k] - base), 32'(cnt));
    for (int i = 0; i < cnt && (base + i) < log_n[k]; i++) begin
      chk($sformatf("%s_nib%0d", name, i), 32'(log_a[k][base + i]),
          (exp >> (4 * (cnt - 1 - i))) & 32'hF);
    end
    chk({name, "_done"}, 32'(done_n[k] - dbase), 32'(ndone));
  endtask

  int b, d;

  initial begin
    tick(2);
    chk("reset_out", 32'(out0), 32'h0);
    chk("reset_busy", 32'({en0, busy0, done0}), 32'h0);
    reset = 1'b0;
    tick(2);

    // Plain 2-nibble word
    b = log_n[0]; d = done_n[0];
    in0 = 8'hA5; start0 = 1'b1; tick(); start0 = 1'b0;
    tick(4);
    check_log("a5", 0, b, d, 32'hA5, 2, 1);

    // Stall of three cycles after the first nibble
    b = log_n[0]; d = done_n[0];
    start0 = 1'b1; tick(); start0 = 1'b0;
    tick();
    rdy0 = 1'b0; #1;
    chk("stall_out", 32'(out0), 32'h5);
    chk("stall_en", 32'(en0), 32'h0);
    tick(3);
    rdy0 = 1'b1;
    tick(3);
    check_log("stall", 0, b, d, 32'hA5, 2, 1);

    // Start held while busy is ignored; start in the cycle after done is taken
    b = log_n[0]; d = done_n[0];
    in0 = 8'hA5; start0 = 1'b1; tick();
    in0 = 8'hFF;
    tick(3);
    tick(); start0 = 1'b0;
    tick(4);
    check_log("busy_start", 0, b, d, 32'hA5FF, 4, 2);

    // Reset in the first SEND cycle abandons the word
    b = log_n[0]; d = done_n[0];
    in0 = 8'hA5; start0 = 1'b1; tick(); start0 = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rst_out", 32'(out0), 32'h0);
    chk("rst_en_busy", 32'({en0, busy0}), 32'h0);
    tick(3);
    check_log("rst", 0, b, d, 32'hA, 1, 0);

    // Four-nibble word
    b = log_n[1]; d = done_n[1];
    in1 = 16'h1234; start1 = 1'b1; tick(); start1 = 1'b0;
    in1 = 16'hFFFF;
    tick(4);
    chk("w4_done_cycle", 32'(done1), 32'h1);
    tick(2);
    check_log("w1234", 1, b, d, 32'h1234, 4, 1);

    // Four-nibble word with an interleaved stall
    b = log_n[1]; d = done_n[1];
    in1 = 16'hBEEF; start1 = 1'b1; tick(); start1 = 1'b0;
    tick(); rdy1 = 1'b0; tick(2); rdy1 = 1'b1; tick(); rdy1 = 1'b0; tick(); rdy1 = 1'b1;
    tick(4);
    check_log("wbeef", 1, b, d, 32'hBEEF, 4, 1);

    // Back-to-back words with start held high
    b = log_n[0]; d = done_n[0];
    in0 = 8'h3C; start0 = 1'b1; tick();
    in0 = 8'hC3;
    tick(4); start0 = 1'b0;
    tick(5);
    check_log("b2b", 0, b, d, 32'h3CC3, 4, 2);

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
